// File: rtl/vec_regfile_mp_pkg.sv
// Shared constants, FSM state and index helpers for vec_regfile_mp.
// Index layout: reg in the low REG_ADDR_W bits, elem in the high bits.
package vec_rf_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int REG_ADDR_W_DEF  = 5;
  localparam int ELEM_ADDR_W_DEF = 5;
  localparam int NUM_WR_DEF      = 2;
  localparam int NUM_RD_DEF      = 2;

  function automatic int idx_w(
    input int reg_w,
    input int elem_w
  );
    return reg_w + elem_w;
  endfunction

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  function automatic logic [31:0] idx_reg(
    input logic [31:0] idx,
    input int          reg_w
  );
    return idx & ((32'd1 << reg_w) - 32'd1);
  endfunction

  function automatic logic [31:0] idx_elem(
    input logic [31:0] idx,
    input int          reg_w
  );
    return idx >> reg_w;
  endfunction

endpackage

// File: rtl/vec_regfile_mp_if.sv
// Write and read request/response bundle of vec_regfile_mp.
// master = issue stage / operand collectors, slave = register file.
interface vec_rf_if
  import vec_rf_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int IDX_W        = 10,
  parameter int NUM_WR_PORTS = NUM_WR_DEF,
  parameter int NUM_RD_PORTS = NUM_RD_DEF
);

  logic [NUM_WR_PORTS-1:0]        wr_val;
  logic [NUM_WR_PORTS-1:0]        wr_rdy;
  logic [NUM_WR_PORTS*IDX_W-1:0]  wr_index;
  logic [NUM_WR_PORTS*DATA_W-1:0] wr_msg;

  logic [NUM_RD_PORTS-1:0]        rd_req_val;
  logic [NUM_RD_PORTS-1:0]        rd_req_rdy;
  logic [NUM_RD_PORTS*IDX_W-1:0]  rd_req_index;
  logic [NUM_RD_PORTS-1:0]        rd_resp_val;
  logic [NUM_RD_PORTS-1:0]        rd_resp_rdy;
  logic [NUM_RD_PORTS*DATA_W-1:0] rd_resp_msg;

  modport master (
    output wr_val, wr_index, wr_msg,
    output rd_req_val, rd_req_index,
    output rd_resp_rdy,
    input  wr_rdy, rd_req_rdy,
    input  rd_resp_val, rd_resp_msg
  );

  modport slave (
    input  wr_val, wr_index, wr_msg,
    input  rd_req_val, rd_req_index,
    input  rd_resp_rdy,
    output wr_rdy, rd_req_rdy,
    output rd_resp_val, rd_resp_msg
  );

endinterface

// File: rtl/vec_regfile_mp_rd_port.sv
// One read port: request/response pipeline register, optional bypass.
// Ports: ready, req val/rdy/index, arr_data, wr_* (bypass), resp val/rdy/msg.
module vec_rf_rd_port
  import vec_rf_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int IDX_W        = 10,
  parameter int NUM_WR_PORTS = NUM_WR_DEF
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           ready,
  input  logic                           req_val,
  output logic                           req_rdy,
  input  logic [DATA_W-1:0]              arr_data,
`ifdef VEC_RF_BYPASS_EN
  input  logic [IDX_W-1:0]               req_index,
  input  logic [NUM_WR_PORTS-1:0]        wr_fire,
  input  logic [NUM_WR_PORTS*IDX_W-1:0]  wr_index,
  input  logic [NUM_WR_PORTS*DATA_W-1:0] wr_msg,
`endif
  output logic                           resp_val,
  input  logic                           resp_rdy,
  output logic [DATA_W-1:0]              resp_msg
);

  logic [DATA_W-1:0] rd_data;
  logic              fire;

`ifdef VEC_RF_BYPASS_EN
  // Later ports override earlier ones, matching write priority.
  always_comb begin
    rd_data = arr_data;
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      if (wr_fire[w] &&
          wr_index[w*IDX_W +: IDX_W] == req_index)
        rd_data = wr_msg[w*DATA_W +: DATA_W];
    end
  end
`else
  assign rd_data = arr_data;
`endif

  assign req_rdy = ready && (!resp_val || resp_rdy);
  assign fire    = req_val && req_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_val <= 1'b0;
      resp_msg <= '0;
    end else if (fire) begin
      resp_val <= 1'b1;
      resp_msg <= rd_data;
    end else if (resp_rdy) begin
      resp_val <= 1'b0;
    end
  end

endmodule

// File: rtl/vec_regfile_mp.sv
// N-write / M-read vector register file with sweep clear FSM.
// Ports: clk, reset_n, clear, init_done, bus (vec_rf_if.slave). Macro VEC_RF_BYPASS_EN.
module vec_regfile_mp
  import vec_rf_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int ELEM_ADDR_W  = ELEM_ADDR_W_DEF,
  parameter int NUM_WR_PORTS = NUM_WR_DEF,
  parameter int NUM_RD_PORTS = NUM_RD_DEF
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     clear,
  output logic     init_done,
  vec_rf_if.slave  bus
);

  localparam int IDX_W     = idx_w(REG_ADDR_W, ELEM_ADDR_W);
  localparam int NUM_REGS  = 1 << REG_ADDR_W;
  localparam int NUM_ELEMS = 1 << ELEM_ADDR_W;

  state_t                   state;
  logic [ELEM_ADDR_W-1:0]   cnt;
  logic [NUM_WR_PORTS-1:0]  wr_fire;

  logic [DATA_W-1:0]      mem [NUM_ELEMS][NUM_REGS];

  logic [REG_ADDR_W-1:0]  wr_reg  [NUM_WR_PORTS];
  logic [ELEM_ADDR_W-1:0] wr_elem [NUM_WR_PORTS];
  logic [REG_ADDR_W-1:0]  rd_reg  [NUM_RD_PORTS];
  logic [ELEM_ADDR_W-1:0] rd_elem [NUM_RD_PORTS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      unique case (state)
        ST_INIT: begin
          if (clear) begin
            cnt <= '0;
          end else if (cnt == '1) begin
            state     <= ST_READY;
            init_done <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_READY: begin
          if (clear) begin
            state     <= ST_INIT;
            init_done <= 1'b0;
            cnt       <= '0;
          end
        end
      endcase
    end
  end

  assign bus.wr_rdy = {NUM_WR_PORTS{init_done}};
  assign wr_fire    = bus.wr_val & bus.wr_rdy;

  always_comb begin
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      wr_reg[p]  = REG_ADDR_W'(idx_reg(
        32'(bus.wr_index[p*IDX_W +: IDX_W]), REG_ADDR_W));
      wr_elem[p] = ELEM_ADDR_W'(idx_elem(
        32'(bus.wr_index[p*IDX_W +: IDX_W]), REG_ADDR_W));
    end
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_reg[p]  = REG_ADDR_W'(idx_reg(
        32'(bus.rd_req_index[p*IDX_W +: IDX_W]), REG_ADDR_W));
      rd_elem[p] = ELEM_ADDR_W'(idx_elem(
        32'(bus.rd_req_index[p*IDX_W +: IDX_W]), REG_ADDR_W));
    end
  end

  // Array has no reset; the INIT sweep zeroes one element per cycle.
  // Port loop order gives the highest port priority on collisions.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      for (int r = 0; r < NUM_REGS; r++)
        mem[cnt][r] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        if (wr_fire[p])
          mem[wr_elem[p]][wr_reg[p]] <=
            bus.wr_msg[p*DATA_W +: DATA_W];
      end
    end
  end

  logic [NUM_RD_PORTS-1:0] req_rdy_w;
  logic [NUM_RD_PORTS-1:0] resp_val_w;
  logic [DATA_W-1:0]       resp_msg_w [NUM_RD_PORTS];

  assign bus.rd_req_rdy  = req_rdy_w;
  assign bus.rd_resp_val = resp_val_w;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    vec_rf_rd_port #(
      .DATA_W       (DATA_W),
      .IDX_W        (IDX_W),
      .NUM_WR_PORTS (NUM_WR_PORTS)
    ) u_rd (
      .clk       (clk),
      .reset_n   (reset_n),
      .ready     (init_done),
      .req_val   (bus.rd_req_val[p]),
      .req_rdy   (req_rdy_w[p]),
      .arr_data  (mem[rd_elem[p]][rd_reg[p]]),
`ifdef VEC_RF_BYPASS_EN
      .req_index (bus.rd_req_index[p*IDX_W +: IDX_W]),
      .wr_fire   (wr_fire),
      .wr_index  (bus.wr_index),
      .wr_msg    (bus.wr_msg),
`endif
      .resp_val  (resp_val_w[p]),
      .resp_rdy  (bus.rd_resp_rdy[p]),
      .resp_msg  (resp_msg_w[p])
    );

    assign bus.rd_resp_msg[p*DATA_W +: DATA_W] = resp_msg_w[p];
  end

endmodule
